// File: rtl/wgt_buf_pkg.sv
// Shared constants and helpers for the weight-bank ring: lane width,
// ring pointer advance and per-lane even parity.
package wgt_buf_pkg;

  localparam int unsigned LANE_W = 8;

  function automatic int unsigned next_bank(input int unsigned ptr,
                                            input int unsigned num_banks);
    return (ptr == num_banks - 1) ? 0 : ptr + 1;
  endfunction

  function automatic logic lane_parity(input logic [LANE_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/wgt_bank_sram.sv
// Flat bank storage addressed by {bank, addr}: one write port and one
// registered read port, no reset on the array or read register.
module wgt_bank_sram #(
  parameter int unsigned DATA_W = 112,
  parameter int unsigned AW     = 9,
  parameter int unsigned DEPTH  = 512
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/wgt_bank_ring.sv
// N-bank weight buffer ring with hardware-owned write/read pointers.
// Optional per-lane parity enabled by defining WGT_BUF_PARITY_EN.
module wgt_bank_ring
  import wgt_buf_pkg::*;
#(
  parameter int unsigned TN         = 14,
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned NUM_BANKS  = 4,
  parameter int unsigned BANK_W     = $clog2(NUM_BANKS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we,
  input  logic [ADDR_WIDTH-1:0]  waddr,
  input  logic [TN*LANE_W-1:0]   wdata,
  input  logic                   wr_commit,
  output logic                   wr_ready,
  output logic [BANK_W-1:0]      wr_bank,
  input  logic                   rd_en,
  input  logic [ADDR_WIDTH-1:0]  k_idx,
  input  logic                   rd_release,
  output logic                   rd_ready,
  output logic [BANK_W-1:0]      rd_bank,
  output logic [TN*LANE_W-1:0]   b_vec,
  output logic                   b_valid,
  output logic [BANK_W:0]        occupancy,
  output logic                   ovf_err,
  output logic                   udf_err
`ifdef WGT_BUF_PARITY_EN
  ,
  output logic                   par_err,
  output logic                   par_err_sticky
`endif
);

  localparam int unsigned DATA_W = TN * LANE_W;
  localparam int unsigned DEPTH  = NUM_BANKS * (2 ** ADDR_WIDTH);
  localparam int unsigned AW     = BANK_W + ADDR_WIDTH;
`ifdef WGT_BUF_PARITY_EN
  localparam int unsigned MEM_W  = DATA_W + TN;
`else
  localparam int unsigned MEM_W  = DATA_W;
`endif
  localparam logic [BANK_W:0] FULL_CNT = (BANK_W+1)'(NUM_BANKS);
  localparam logic [BANK_W:0] ONE_CNT  = (BANK_W+1)'(1);

  logic [BANK_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [BANK_W:0]   occ_q, occ_d;
  logic              rd_v_q, b_valid_q, ovf_q, udf_q;
  logic [DATA_W-1:0] b_vec_q;
  logic [MEM_W-1:0]  mem_wdata, mem_rdata;
  logic              do_wr, do_commit, do_rd, do_rel;

  assign wr_ready  = (occ_q < FULL_CNT);
  assign rd_ready  = (occ_q != '0);
  assign do_wr     = we & wr_ready;
  assign do_commit = wr_commit & wr_ready;
  assign do_rd     = rd_en & rd_ready;
  assign do_rel    = rd_release & rd_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (do_commit) wr_ptr_d = BANK_W'(next_bank(32'(wr_ptr_q), NUM_BANKS));
    if (do_rel)    rd_ptr_d = BANK_W'(next_bank(32'(rd_ptr_q), NUM_BANKS));
    case ({do_commit, do_rel})
      2'b10:   occ_d = occ_q + ONE_CNT;
      2'b01:   occ_d = occ_q - ONE_CNT;
      default: occ_d = occ_q;
    endcase
  end

  // Same-cycle write/read use the pre-advance pointers, so they hit the old banks.
  wgt_bank_sram #(
    .DATA_W (MEM_W),
    .AW     (AW),
    .DEPTH  (DEPTH)
  ) u_sram (
    .clk     (clk),
    .we_i    (do_wr),
    .waddr_i ({wr_ptr_q, waddr}),
    .wdata_i (mem_wdata),
    .re_i    (do_rd),
    .raddr_i ({rd_ptr_q, k_idx}),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      rd_v_q    <= 1'b0;
      b_valid_q <= 1'b0;
      b_vec_q   <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      rd_v_q    <= do_rd;
      b_valid_q <= rd_v_q;
      if (rd_v_q) b_vec_q <= mem_rdata[DATA_W-1:0];
      ovf_q     <= ovf_q | ((we | wr_commit) & ~wr_ready);
      udf_q     <= udf_q | ((rd_en | rd_release) & ~rd_ready);
    end
  end

`ifdef WGT_BUF_PARITY_EN
  logic [TN-1:0] wpar, rpar;
  logic          par_err_q, par_sticky_q;

  always_comb begin
    wpar = '0;
    rpar = '0;
    for (int unsigned i = 0; i < TN; i++) begin
      wpar[i] = lane_parity(wdata[i*LANE_W +: LANE_W]);
      rpar[i] = lane_parity(mem_rdata[i*LANE_W +: LANE_W]);
    end
  end

  assign mem_wdata = {wpar, wdata};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err_q    <= 1'b0;
      par_sticky_q <= 1'b0;
    end else begin
      par_err_q    <= rd_v_q & (rpar != mem_rdata[MEM_W-1:DATA_W]);
      par_sticky_q <= par_sticky_q | (rd_v_q & (rpar != mem_rdata[MEM_W-1:DATA_W]));
    end
  end

  assign par_err        = par_err_q;
  assign par_err_sticky = par_sticky_q;
`else
  assign mem_wdata = wdata;
`endif

  assign wr_bank   = wr_ptr_q;
  assign rd_bank   = rd_ptr_q;
  assign occupancy = occ_q;
  assign b_vec     = b_vec_q;
  assign b_valid   = b_valid_q;
  assign ovf_err   = ovf_q;
  assign udf_err   = udf_q;

endmodule

// File: tb/tb_wgt_bank_ring.sv
// Directed + randomized bench for wgt_bank_ring against a bank-array model.
// Parity checks are compiled in when WGT_BUF_PARITY_EN is defined.
module tb_wgt_bank_ring;

  localparam int unsigned TN    = 14;
  localparam int unsigned AWD   = 7;
  localparam int unsigned NB    = 4;
  localparam int unsigned BW    = 2;
  localparam int unsigned DW    = TN * 8;
  localparam int unsigned DEPTH = 1 << AWD;

  logic           clk = 1'b0, rst_n = 1'b0;
  logic           we = 1'b0, wr_commit = 1'b0, rd_en = 1'b0, rd_release = 1'b0;
  logic [AWD-1:0] waddr = '0, k_idx = '0;
  logic [DW-1:0]  wdata = '0, b_vec;
  logic           wr_ready, rd_ready, b_valid, ovf_err, udf_err;
  logic [BW-1:0]  wr_bank, rd_bank;
  logic [BW:0]    occupancy;
`ifdef WGT_BUF_PARITY_EN
  logic           par_err, par_err_sticky;
`endif

  int checks = 0, errors = 0, bv_count = 0;

  // Reference model: whole banks as arrays, ring positions as plain integers.
  logic [DW-1:0] mem_m [NB][DEPTH];
  int            wr_b, rd_b, occ_m;
  bit            ovf_m, udf_m, p1_v, bval_m, p1_par, par_m, parst_m, rd_corrupt;
  logic [DW-1:0] p1_d, bvec_m;

  wgt_bank_ring #(.TN(TN), .ADDR_WIDTH(AWD), .NUM_BANKS(NB)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .wr_commit(wr_commit), .wr_ready(wr_ready), .wr_bank(wr_bank),
    .rd_en(rd_en), .k_idx(k_idx), .rd_release(rd_release), .rd_ready(rd_ready),
    .rd_bank(rd_bank), .b_vec(b_vec), .b_valid(b_valid), .occupancy(occupancy),
    .ovf_err(ovf_err), .udf_err(udf_err)
`ifdef WGT_BUF_PARITY_EN
    , .par_err(par_err), .par_err_sticky(par_err_sticky)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int a);
    logic [DW-1:0] w;
    for (int l = 0; l < TN; l++) w[l*8 +: 8] = 8'((a << 1) ^ (l * 37));
    return w;
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int l = 0; l < TN; l++) w[l*8 +: 8] = 8'($urandom);
    return w;
  endfunction

  task automatic model_reset();
    wr_b = 0; rd_b = 0; occ_m = 0;
    ovf_m = 0; udf_m = 0; p1_v = 0; bval_m = 0; bvec_m = '0;
    p1_par = 0; par_m = 0; parst_m = 0;
  endtask

  task automatic model_edge();
    bit            wr_ok, rd_ok, nv, nc, nr;
    logic [DW-1:0] nd;
    wr_ok = (occ_m < NB);
    rd_ok = (occ_m != 0);
    nv = 0; nd = '0; nc = 0; nr = 0;
    if (rd_en) begin
      if (rd_ok) begin nv = 1; nd = mem_m[rd_b][k_idx]; end
      else udf_m = 1;
    end
    if (we) begin
      if (wr_ok) mem_m[wr_b][waddr] = wdata;
      else ovf_m = 1;
    end
    if (wr_commit) begin
      if (wr_ok) begin wr_b = (wr_b + 1) % NB; nc = 1; end
      else ovf_m = 1;
    end
    if (rd_release) begin
      if (rd_ok) begin rd_b = (rd_b + 1) % NB; nr = 1; end
      else udf_m = 1;
    end
    occ_m = occ_m + int'(nc) - int'(nr);
    bval_m = p1_v;
    if (p1_v) bvec_m = p1_d;
    par_m = p1_v & p1_par;
    parst_m = parst_m | par_m;
    p1_v = nv; p1_d = nd; p1_par = nv & rd_corrupt;
  endtask

  task automatic compare_all();
    chk("b_valid",   128'(b_valid),   128'(bval_m));
    chk("b_vec",     128'(b_vec),     128'(bvec_m));
    chk("occupancy", 128'(occupancy), 128'(occ_m));
    chk("wr_ready",  128'(wr_ready),  128'(occ_m < NB));
    chk("rd_ready",  128'(rd_ready),  128'(occ_m != 0));
    chk("wr_bank",   128'(wr_bank),   128'(wr_b));
    chk("rd_bank",   128'(rd_bank),   128'(rd_b));
    chk("ovf_err",   128'(ovf_err),   128'(ovf_m));
    chk("udf_err",   128'(udf_err),   128'(udf_m));
`ifdef WGT_BUF_PARITY_EN
    chk("par_err",        128'(par_err),        128'(par_m));
    chk("par_err_sticky", 128'(par_err_sticky), 128'(parst_m));
`endif
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    if (b_valid === 1'b1) bv_count++;
    compare_all();
    we = 0; wr_commit = 0; rd_en = 0; rd_release = 0; rd_corrupt = 0;
  endtask

  initial begin
    int            wb0, rb0, n;
    logic [DW-1:0] old_w;

    model_reset();
    rd_corrupt = 0;
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;

    // Fill bank 0 with a known pattern; commit rides on the last write.
    for (int a = 0; a < int'(DEPTH); a++) begin
      we = 1; waddr = AWD'(a); wdata = pat(a); wr_commit = (a == int'(DEPTH) - 1);
      step();
    end
    chk("fill_wr_bank", 128'(wr_bank), 128'(1));
    chk("fill_occ", 128'(occupancy), 128'(1));
    bv_count = 0;
    for (int a = 0; a < int'(DEPTH); a++) begin
      rd_en = 1; k_idx = AWD'(a);
      step();
    end
    step(); step();
    chk("bvalid_run", 128'(bv_count), 128'(DEPTH));

    // Fill the ring, then try to write/commit while full.
    repeat (3) begin wr_commit = 1; step(); end
    chk("full_occ", 128'(occupancy), 128'(NB));
    chk("full_wr_ready", 128'(wr_ready), 128'(0));
    we = 1; waddr = AWD'(5); wdata = ~pat(5); wr_commit = 1;
    step();
    chk("ovf_set", 128'(ovf_err), 128'(1));
    chk("ovf_wr_bank", 128'(wr_bank), 128'(0));
    rd_en = 1; k_idx = AWD'(5);
    step(); step(); step();
    chk("bank0_kept", 128'(b_vec), 128'(pat(5)));
    repeat (NB) begin rd_release = 1; step(); end
    chk("empty_occ", 128'(occupancy), 128'(0));

    // Underflow: read and release at occupancy 0.
    rd_en = 1; k_idx = AWD'(3); rd_release = 1;
    step(); step(); step();
    chk("udf_set", 128'(udf_err), 128'(1));
    chk("udf_bvec_hold", 128'(b_vec), 128'(pat(5)));
    chk("udf_rd_bank", 128'(rd_bank), 128'(0));

    // Six commit/release rounds across the wrap.
    for (int r = 0; r < 6; r++) begin
      chk("wrap_wr_bank", 128'(wr_bank), 128'(r % NB));
      for (int a = 0; a < 8; a++) begin
        we = 1; waddr = AWD'(a); wdata = rand_word(); wr_commit = (a == 7);
        step();
      end
      chk("wrap_rd_bank", 128'(rd_bank), 128'(r % NB));
      for (int i = 0; i < 8; i++) begin
        rd_en = 1; k_idx = AWD'($urandom_range(0, 7)); rd_release = (i == 7);
        step();
      end
      step(); step();
    end

    // Same-cycle commit and release at occupancy 2.
    for (int b = 0; b < 2; b++) begin
      for (int a = 0; a < 8; a++) begin
        we = 1; waddr = AWD'(a); wdata = rand_word(); wr_commit = (a == 7);
        step();
      end
    end
    chk("same_occ_before", 128'(occupancy), 128'(2));
    wb0 = wr_b; rb0 = rd_b; old_w = mem_m[rd_b][2];
    we = 1; waddr = AWD'(0); wdata = rand_word();
    wr_commit = 1; rd_en = 1; k_idx = AWD'(2); rd_release = 1;
    step();
    chk("same_occ_after", 128'(occupancy), 128'(2));
    chk("same_wr_adv", 128'(wr_bank), 128'((wb0 + 1) % NB));
    chk("same_rd_adv", 128'(rd_bank), 128'((rb0 + 1) % NB));
    step();
    chk("same_old_word", 128'(b_vec), 128'(old_w));
    n = occ_m;
    for (int i = 0; i < n; i++) begin rd_release = 1; step(); end

    // Randomized traffic restricted to words 0..7, all of which hold known data.
    for (int i = 0; i < 400; i++) begin
      we = ($urandom_range(0, 1) == 1); waddr = AWD'($urandom_range(0, 7)); wdata = rand_word();
      wr_commit = ($urandom_range(0, 5) == 0);
      rd_en = ($urandom_range(0, 1) == 1); k_idx = AWD'($urandom_range(0, 7));
      rd_release = ($urandom_range(0, 5) == 0);
      step();
    end
    step(); step();

`ifdef WGT_BUF_PARITY_EN
    n = occ_m;
    for (int i = 0; i < n; i++) begin rd_release = 1; step(); end
    wb0 = wr_b;
    we = 1; waddr = AWD'(0); wdata = rand_word(); wr_commit = 1;
    step();
    dut.u_sram.mem[wb0 * int'(DEPTH)][DW] = ~dut.u_sram.mem[wb0 * int'(DEPTH)][DW];
    rd_en = 1; k_idx = AWD'(0); rd_corrupt = 1;
    step(); step();
    chk("par_pulse", 128'(par_err), 128'(1));
    step();
    chk("par_sticky", 128'(par_err_sticky), 128'(1));
    rd_release = 1;
    step();
`endif

    // Asynchronous reset with reads in flight.
    if (occ_m == 0) begin
      we = 1; waddr = AWD'(0); wdata = rand_word(); wr_commit = 1;
      step();
    end
    rd_en = 1; k_idx = AWD'(0);
    step();
    rd_en = 1; k_idx = AWD'(1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    chk("rst_bvalid", 128'(b_valid), 128'(0));
    rd_en = 0;
    rst_n = 1'b1;
    step(); step();
    chk("post_rst_occ", 128'(occupancy), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wgt_bank_ring.md
Name: wgt_bank_ring

Overview:
- N-bank generalisation of the ping-pong weight buffer; NUM_BANKS banks form a ring with hardware-managed bank ownership.
- The DMA fills the bank at the write pointer and commits it; the systolic array drains the bank at the read pointer and releases it.
- The block replaces external bank_sel_wr/bank_sel_rd steering with internal pointers, an occupancy count and ready flags.
- Sits between the DMA weight path and the systolic-array B inputs, TN lanes wide.

Parameters:
- TN, 14, number of int8 lanes per word (1-1024).
- ADDR_WIDTH, 7, word address width per bank; depth = 2**ADDR_WIDTH (1-12).
- NUM_BANKS, 4, number of banks in the ring (2-16; need not be a power of 2).
- BANK_W, $clog2(NUM_BANKS), derived bank-index width; not to be overridden.

Ports:
- clk  in  1  single clock; all flops on clk, no gated clock.
- rst_n  in  1  asynchronous active-low reset.
- we  in  1  write strobe to the current write bank.
- waddr  in  ADDR_WIDTH  word address within the write bank.
- wdata  in  TN*8  write word.
- wr_commit  in  1  marks the write bank full and advances wr_ptr.
- wr_ready  out  1  a free bank is available for writing.
- wr_bank  out  BANK_W  current write bank index (wr_ptr).
- rd_en  in  1  read strobe from the current read bank.
- k_idx  in  ADDR_WIDTH  word address within the read bank.
- rd_release  in  1  frees the read bank and advances rd_ptr.
- rd_ready  out  1  at least one full bank is available.
- rd_bank  out  BANK_W  current read bank index (rd_ptr).
- b_vec  out  TN*8  read data.
- b_valid  out  1  b_vec updated this cycle.
- occupancy  out  BANK_W+1  number of full banks.
- ovf_err  out  1  sticky: we or wr_commit while !wr_ready.
- udf_err  out  1  sticky: rd_en or rd_release while !rd_ready.

Behaviour:
- Reset values: wr_ptr=0, rd_ptr=0, occupancy=0, b_vec=0, b_valid=0, ovf_err=0, udf_err=0. Memory contents are not reset.
- Flags (combinational from registered state): wr_ready = (occupancy < NUM_BANKS); rd_ready = (occupancy != 0).
- Write:
  - we && wr_ready writes mem[wr_ptr][waddr].
  - we && !wr_ready is dropped and sets ovf_err.
- Commit:
  - wr_commit && wr_ready: wr_ptr <= (wr_ptr == NUM_BANKS-1) ? 0 : wr_ptr+1; occupancy increments.
  - A write in the same cycle as a commit lands in the old bank.
  - A commit with no preceding writes is legal; the bank holds stale data.
- Read:
  - rd_en && rd_ready at cycle t: array read registered at t+1, output register at t+2.
  - b_vec is valid at t+2 with b_valid=1 for exactly that cycle. Fully pipelined: one read per cycle.
  - rd_en && !rd_ready produces no b_valid and sets udf_err.
  - b_vec holds its last value when b_valid=0.
- Release:
  - rd_release && rd_ready: rd_ptr advances with the same wrap rule; occupancy decrements.
  - rd_en in the same cycle as a release reads the old bank; in-flight reads complete normally.
- Simultaneous commit and release (both legal): both pointers advance and occupancy is unchanged.
- Illegal commit/release: pointers and occupancy are untouched; only the sticky error bit is set.
- Bank disjointness: the write bank never equals a full bank, so no read-during-write hazard exists on the same word. The one exception is occupancy==0, and rd is then illegal.
- Sticky errors clear only on reset.
- Reset mid-operation: pipeline valid bits and all state return to reset values immediately; in-flight reads are discarded.

Optional Feature:
- Macro: WGT_BUF_PARITY_EN.
- When defined:
  - Each stored word carries TN even-parity bits, one per lane, computed on write.
  - Parity is checked at the output stage.
  - Output par_err (1 bit) pulses with b_valid when any lane mismatches.
  - Output par_err_sticky latches until reset.
  - b_vec data is passed through uncorrected.
- When undefined: no parity storage; par_err and par_err_sticky ports are absent.

Decomposition:
- Package wgt_buf_pkg holds:
  - the lane width constant LANE_W=8;
  - the function next_bank(ptr, NUM_BANKS) used by both pointers;
  - the parity function lane_parity(word).
- One sub-module: wgt_bank_sram.
  - Flat NUM_BANKS*2**ADDR_WIDTH array addressed by {bank, addr}.
  - One write port and one registered read port, BRAM-inferable.
  - Pointers, occupancy, errors and the output stage stay in wgt_bank_ring.

Test Plan (NUM_BANKS=4, TN=14):
- Fill bank0 words 0..127 with pattern {addr,lane}, commit; rd_en k_idx=0..127 back-to-back -> b_vec matches pattern at t+2, b_valid high 128 consecutive cycles, occupancy=1.
- Commit 4 banks without release -> wr_ready=0, occupancy=4; extra we -> dropped (bank0 data unchanged) and ovf_err=1.
- Wrap: 6 commit/release rounds -> wr_bank/rd_bank sequence 0,1,2,3,0,1; data per round is distinct and correct.
- Same-cycle commit+release with occupancy=2 -> occupancy stays 2, both pointers +1; rd_en in the release cycle returns the old-bank word.
- rd_en at occupancy=0 -> no b_valid, udf_err=1, b_vec unchanged.
- Assert rst_n with 2 reads in flight -> b_valid stays 0, all outputs at reset values next cycle; with WGT_BUF_PARITY_EN, forcing a stored bit flip -> par_err pulses with that word.
